grf_multiport: RTL and testbench

//  Parametrised general register file for the multi-issue pipeline. NUM_RD combinational read ports with

---
 rtl/grf_pkg.sv | 40 ++++
 rtl/grf_multiport_if.sv | 37 +++
 rtl/grf_scoreboard.sv | 40 ++++
 rtl/grf_multiport.sv | 154 +++++++++++++++
 tb/tb_grf_multiport.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/grf_pkg.sv
// Shared types and the write-port arbitration helper for the general register file.
// The same helper decides write commit, read bypass and trace ownership, so all three agree.
package grf_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_PC_W   = 32;

   // Arbitration helper capacity; instances must stay within these bounds.
   localparam int GRF_MAX_WR = 8;
   localparam int GRF_MAX_AW = 8;
   localparam int GRF_IDX_W  = 3;

   typedef logic [GRF_MAX_WR-1:0]     grf_en_t;
   typedef logic [GRF_MAX_AW-1:0]     grf_addr_t;
   typedef grf_addr_t [GRF_MAX_WR-1:0] grf_addr_vec_t;

   localparam grf_addr_t REG_ZERO = '0;

   typedef struct packed {
      logic                 hit;
      logic [GRF_IDX_W-1:0] idx;
   } grf_sel_t;

   // Highest-index enabled port targeting nonzero address a wins.
   function automatic grf_sel_t grf_sel_wr(input grf_en_t en, input grf_addr_vec_t addr,
                                           input grf_addr_t a);
      grf_sel_t s;
      s.hit = 1'b0;
      s.idx = '0;
      for (int k = 0; k < GRF_MAX_WR; k++) begin
         if (en[k] && (addr[k] == a) && (a != REG_ZERO)) begin
            s.hit = 1'b1;
            s.idx = GRF_IDX_W'(k);
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/grf_multiport_if.sv
// Read, write, issue and trace bus of the general register file.
interface grf_multiport_if
   import grf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2,
   parameter int PC_W   = DEF_PC_W
) ();

   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic [NUM_WR*PC_W-1:0]   wr_pc;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic [NUM_WR-1:0]        trace_valid;
   logic [NUM_WR*PC_W-1:0]   trace_pc;
   logic [NUM_WR*ADDR_W-1:0] trace_addr;
   logic [NUM_WR*DATA_W-1:0] trace_data;
   logic                     wr_collide;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_en, iss_addr,
      input  rd_data, rd_busy, trace_valid, trace_pc, trace_addr, trace_data, wr_collide
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_en, iss_addr,
      output rd_data, rd_busy, trace_valid, trace_pc, trace_addr, trace_data, wr_collide
   );

endinterface

// File: rtl/grf_scoreboard.sv
// Per-register busy bits: set at issue, cleared by committed writeback; issue wins a same-edge tie.
module grf_scoreboard #(
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     set_en,
   input  logic [ADDR_W-1:0]        set_addr,
   input  logic [2**ADDR_W-1:0]     clr_vec,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]        rd_busy
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_next;

   always_comb begin
      busy_next = busy & ~clr_vec;
      if (set_en)
         busy_next[set_addr] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         busy <= '0;
      else
         busy <= busy_next;
   end

   always_comb begin
      rd_busy = '0;
      for (int p = 0; p < NUM_RD; p++)
         rd_busy[p] = busy[rd_addr[p*ADDR_W +: ADDR_W]];
   end

endmodule

// File: rtl/grf_multiport.sv
// Multi-port general register file: bypassed combinational reads, prioritised synchronous writes,
// busy scoreboard, registered per-port writeback trace and sticky same-address collision flag.
module grf_multiport
   import grf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2,
   parameter int PC_W   = DEF_PC_W
) (
   input logic           clk,
   input logic           reset,
   grf_multiport_if.slave bus
);

   localparam int DEPTH = 2**ADDR_W;

   function automatic grf_addr_t pad_addr(input logic [ADDR_W-1:0] a);
      grf_addr_t r;
      r = '0;
      r[ADDR_W-1:0] = a;
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] port_data(input logic [GRF_IDX_W-1:0] idx,
                                                   input logic [NUM_WR*DATA_W-1:0] all);
      logic [DATA_W-1:0] d;
      d = '0;
      for (int k = 0; k < NUM_WR; k++)
         if (idx == GRF_IDX_W'(k))
            d = all[k*DATA_W +: DATA_W];
      return d;
   endfunction

   grf_en_t                      en_pad;
   grf_addr_vec_t                addr_pad;
   logic [DEPTH-1:0]             commit;
   logic [DEPTH-1:0][DATA_W-1:0] commit_data;
   logic [DATA_W-1:0]            mem [DEPTH];
   logic [NUM_RD*DATA_W-1:0]     rd_data_c;
   logic [NUM_RD-1:0]            byp_hit;
   logic [NUM_RD-1:0]            busy_raw;
   logic [NUM_WR-1:0]            tv_next;
   logic                         coll_now;
   logic [NUM_WR-1:0]            trace_valid_q;
   logic [NUM_WR*PC_W-1:0]       trace_pc_q;
   logic [NUM_WR*ADDR_W-1:0]     trace_addr_q;
   logic [NUM_WR*DATA_W-1:0]     trace_data_q;
   logic                         wr_collide_q;

   always_comb begin
      en_pad   = '0;
      addr_pad = '0;
      for (int k = 0; k < NUM_WR; k++) begin
         en_pad[k]   = bus.wr_en[k];
         addr_pad[k] = pad_addr(bus.wr_addr[k*ADDR_W +: ADDR_W]);
      end
   end

   always_comb begin
      commit      = '0;
      commit_data = '0;
      for (int a = 0; a < DEPTH; a++) begin
         grf_sel_t sel;
         sel            = grf_sel_wr(en_pad, addr_pad, GRF_MAX_AW'(a));
         commit[a]      = sel.hit;
         commit_data[a] = port_data(sel.idx, bus.wr_data);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int a = 0; a < DEPTH; a++)
            mem[a] <= '0;
      end else begin
         for (int a = 0; a < DEPTH; a++)
            if (commit[a])
               mem[a] <= commit_data[a];
      end
   end

   // Address 0 never hits the bypass, so it falls through to the constant zero.
   always_comb begin
      rd_data_c = '0;
      byp_hit   = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         logic [ADDR_W-1:0] ra;
         grf_sel_t          sel;
         ra         = bus.rd_addr[p*ADDR_W +: ADDR_W];
         sel        = grf_sel_wr(en_pad, addr_pad, pad_addr(ra));
         byp_hit[p] = sel.hit;
         if (sel.hit)
            rd_data_c[p*DATA_W +: DATA_W] = port_data(sel.idx, bus.wr_data);
         else if (ra != '0)
            rd_data_c[p*DATA_W +: DATA_W] = mem[ra];
      end
   end

   grf_scoreboard #(
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .set_en   (bus.iss_en),
      .set_addr (bus.iss_addr),
      .clr_vec  (commit),
      .rd_addr  (bus.rd_addr),
      .rd_busy  (busy_raw)
   );

   // A port owns its trace slot only if no higher port overrode it; any override is a collision.
   always_comb begin
      tv_next  = '0;
      coll_now = 1'b0;
      for (int k = 0; k < NUM_WR; k++) begin
         grf_sel_t sel;
         sel        = grf_sel_wr(en_pad, addr_pad, addr_pad[k]);
         tv_next[k] = sel.hit && (sel.idx == GRF_IDX_W'(k));
         if (en_pad[k] && sel.hit && (sel.idx != GRF_IDX_W'(k)))
            coll_now = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trace_valid_q <= '0;
         trace_pc_q    <= '0;
         trace_addr_q  <= '0;
         trace_data_q  <= '0;
         wr_collide_q  <= 1'b0;
      end else begin
         trace_valid_q <= tv_next;
         for (int k = 0; k < NUM_WR; k++) begin
            if (tv_next[k]) begin
               trace_pc_q[k*PC_W +: PC_W]       <= bus.wr_pc[k*PC_W +: PC_W];
               trace_addr_q[k*ADDR_W +: ADDR_W] <= bus.wr_addr[k*ADDR_W +: ADDR_W];
               trace_data_q[k*DATA_W +: DATA_W] <= bus.wr_data[k*DATA_W +: DATA_W];
            end
         end
         wr_collide_q <= wr_collide_q | coll_now;
      end
   end

   assign bus.rd_data     = rd_data_c;
   assign bus.rd_busy     = busy_raw & ~byp_hit;
   assign bus.trace_valid = trace_valid_q;
   assign bus.trace_pc    = trace_pc_q;
   assign bus.trace_addr  = trace_addr_q;
   assign bus.trace_data  = trace_data_q;
   assign bus.wr_collide  = wr_collide_q;

endmodule

// File: tb/tb_grf_multiport.sv
// Bench for grf_multiport: directed scenarios with literal expectations plus randomized traffic
// compared every negedge against an array-based model of the register file.
module tb_grf_multiport;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int NW = 2;
   localparam int PW = 32;
   localparam int DEPTH = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   grf_multiport_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .PC_W(PW)) bus ();

   grf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .PC_W(PW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int vectors = 0;
   int errors  = 0;
   bit chk_on  = 1'b0;

   logic [DW-1:0] m_mem  [DEPTH];
   bit            m_busy [DEPTH];
   bit            m_coll;
   bit            m_tv   [NW];
   logic [PW-1:0] m_tpc  [NW];
   logic [AW-1:0] m_taddr[NW];
   logic [DW-1:0] m_tdata[NW];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference: last enabled port (highest index) on an address is the producer seen this cycle.
   function automatic void model_read(input logic [AW-1:0] ra, output logic [DW-1:0] d,
                                      output bit busy);
      bit hit = 1'b0;
      d = m_mem[ra];
      for (int k = 0; k < NW; k++)
         if (bus.wr_en[k] && ra != 0 && bus.wr_addr[k*AW +: AW] == ra) begin
            hit = 1'b1;
            d   = bus.wr_data[k*DW +: DW];
         end
      if (ra == 0) d = '0;
      busy = m_busy[ra] && !hit;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int a = 0; a < DEPTH; a++) begin
            m_mem[a]  = '0;
            m_busy[a] = 1'b0;
         end
         for (int k = 0; k < NW; k++) begin
            m_tv[k] = 1'b0; m_tpc[k] = '0; m_taddr[k] = '0; m_tdata[k] = '0;
         end
         m_coll = 1'b0;
      end else begin
         int last [DEPTH];
         for (int a = 0; a < DEPTH; a++) last[a] = -1;
         for (int k = 0; k < NW; k++) begin
            int a;
            a = int'(bus.wr_addr[k*AW +: AW]);
            if (bus.wr_en[k] && a != 0) begin
               if (last[a] >= 0) m_coll = 1'b1;
               last[a]  = k;
               m_mem[a] = bus.wr_data[k*DW +: DW];
            end
         end
         for (int k = 0; k < NW; k++) begin
            int a;
            a = int'(bus.wr_addr[k*AW +: AW]);
            m_tv[k] = bus.wr_en[k] && a != 0 && last[a] == k;
            if (m_tv[k]) begin
               m_tpc[k]   = bus.wr_pc[k*PW +: PW];
               m_taddr[k] = bus.wr_addr[k*AW +: AW];
               m_tdata[k] = bus.wr_data[k*DW +: DW];
            end
         end
         for (int a = 1; a < DEPTH; a++)
            if (last[a] >= 0) m_busy[a] = 1'b0;
         if (bus.iss_en && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int p = 0; p < NR; p++) begin
            logic [DW-1:0] d;
            bit b;
            model_read(bus.rd_addr[p*AW +: AW], d, b);
            check($sformatf("model rd_data[%0d]", p), 64'(bus.rd_data[p*DW +: DW]), 64'(d));
            check($sformatf("model rd_busy[%0d]", p), 64'(bus.rd_busy[p]), 64'(b));
         end
         for (int k = 0; k < NW; k++) begin
            check($sformatf("model trace_valid[%0d]", k), 64'(bus.trace_valid[k]), 64'(m_tv[k]));
            check($sformatf("model trace_pc[%0d]", k), 64'(bus.trace_pc[k*PW +: PW]), 64'(m_tpc[k]));
            check($sformatf("model trace_addr[%0d]", k), 64'(bus.trace_addr[k*AW +: AW]),
                  64'(m_taddr[k]));
            check($sformatf("model trace_data[%0d]", k), 64'(bus.trace_data[k*DW +: DW]),
                  64'(m_tdata[k]));
         end
         check("model wr_collide", 64'(bus.wr_collide), 64'(m_coll));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_pc = '0;
      bus.iss_en = 1'b0; bus.iss_addr = '0;
   endtask

   task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [PW-1:0] pc);
      bus.wr_en[k]             = 1'b1;
      bus.wr_addr[k*AW +: AW]  = a;
      bus.wr_data[k*DW +: DW]  = d;
      bus.wr_pc[k*PW +: PW]    = pc;
   endtask

   task automatic set_rd(input int p, input logic [AW-1:0] a);
      bus.rd_addr[p*AW +: AW] = a;
   endtask

   initial begin
      reset = 1'b0;
      bus.rd_addr = '0;
      idle();
      #1 reset = 1'b1;
      chk_on = 1'b1;
      @(negedge clk);
      check("reset trace_valid", 64'(bus.trace_valid), 64'd0);
      check("reset wr_collide", 64'(bus.wr_collide), 64'd0);
      check("reset rd_data", 64'(bus.rd_data), 64'd0);
      step();
      reset = 1'b0;

      // Write addr 3 with same-cycle read bypass, then stored value and trace.
      step(); idle();
      set_wr(0, 5'd3, 32'h1234, 32'h100); set_rd(0, 5'd3);
      @(negedge clk);
      check("bypass addr3", 64'(bus.rd_data[0 +: DW]), 64'h1234);
      step(); idle();
      @(negedge clk);
      check("stored addr3", 64'(bus.rd_data[0 +: DW]), 64'h1234);
      check("trace_valid addr3", 64'(bus.trace_valid), 64'b01);
      check("trace_addr addr3", 64'(bus.trace_addr[0 +: AW]), 64'd3);
      check("trace_data addr3", 64'(bus.trace_data[0 +: DW]), 64'h1234);
      check("trace_pc addr3", 64'(bus.trace_pc[0 +: PW]), 64'h100);

      // Both ports on addr 7: higher port wins everywhere, collision sticks.
      step(); idle();
      set_wr(0, 5'd7, 32'hAAAA, 32'h200); set_wr(1, 5'd7, 32'h5555, 32'h204); set_rd(1, 5'd7);
      @(negedge clk);
      check("bypass collide addr7", 64'(bus.rd_data[DW +: DW]), 64'h5555);
      step(); idle();
      @(negedge clk);
      check("stored addr7", 64'(bus.rd_data[DW +: DW]), 64'h5555);
      check("trace_valid collide", 64'(bus.trace_valid), 64'b10);
      check("wr_collide set", 64'(bus.wr_collide), 64'd1);
      step(); step();
      @(negedge clk);
      check("wr_collide sticky", 64'(bus.wr_collide), 64'd1);

      // Async reset mid-cycle while a write to addr 5 is pending, with a busy register.
      step(); idle();
      bus.iss_en = 1'b1; bus.iss_addr = 5'd6;
      step(); idle();
      set_wr(0, 5'd5, 32'hDEAD, 32'h300); set_rd(0, 5'd6); set_rd(1, 5'd7);
      #2 reset = 1'b1;
      #1;
      check("reset rd_data0", 64'(bus.rd_data[0 +: DW]), 64'd0);
      check("reset rd_data1", 64'(bus.rd_data[DW +: DW]), 64'd0);
      check("reset rd_busy", 64'(bus.rd_busy), 64'd0);
      check("reset mid trace_valid", 64'(bus.trace_valid), 64'd0);
      check("reset mid wr_collide", 64'(bus.wr_collide), 64'd0);
      step(); idle();
      reset = 1'b0; set_rd(0, 5'd5);
      @(negedge clk);
      check("write discarded addr5", 64'(bus.rd_data[0 +: DW]), 64'd0);

      // Writes to address 0 on both ports: ignored, no trace, no collision.
      step(); idle();
      set_wr(0, 5'd0, 32'hFFFFFFFF, 32'h400); set_wr(1, 5'd0, 32'hFFFFFFFF, 32'h404);
      set_rd(0, 5'd0);
      @(negedge clk);
      check("read addr0 bypass", 64'(bus.rd_data[0 +: DW]), 64'd0);
      step(); idle();
      @(negedge clk);
      check("read addr0 stored", 64'(bus.rd_data[0 +: DW]), 64'd0);
      check("addr0 trace_valid", 64'(bus.trace_valid), 64'd0);
      check("addr0 wr_collide", 64'(bus.wr_collide), 64'd0);

      // Issue addr 9, then producer writeback bypasses and clears busy.
      step(); idle();
      bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
      step(); idle();
      set_rd(0, 5'd9);
      @(negedge clk);
      check("busy addr9", 64'(bus.rd_busy[0]), 64'd1);
      step(); idle();
      set_wr(0, 5'd9, 32'h99, 32'h500);
      @(negedge clk);
      check("busy addr9 bypassed", 64'(bus.rd_busy[0]), 64'd0);
      check("bypass addr9", 64'(bus.rd_data[0 +: DW]), 64'h99);
      step(); idle();
      @(negedge clk);
      check("busy addr9 cleared", 64'(bus.rd_busy[0]), 64'd0);

      // Issue and write to addr 4 on the same edge: new producer keeps it busy.
      step(); idle();
      bus.iss_en = 1'b1; bus.iss_addr = 5'd4; set_wr(1, 5'd4, 32'h44, 32'h600);
      step(); idle();
      set_rd(0, 5'd4);
      @(negedge clk);
      check("busy addr4 kept", 64'(bus.rd_busy[0]), 64'd1);
      step(); idle();
      set_wr(0, 5'd4, 32'h4444, 32'h604);
      @(negedge clk);
      check("busy addr4 bypassed", 64'(bus.rd_busy[0]), 64'd0);
      step(); idle();
      @(negedge clk);
      check("busy addr4 cleared", 64'(bus.rd_busy[0]), 64'd0);
      check("stored addr4", 64'(bus.rd_data[0 +: DW]), 64'h4444);

      // Randomized traffic on a narrow address window, with occasional async resets.
      for (int i = 0; i < 1500; i++) begin
         step();
         if (reset) reset = 1'b0;
         idle();
         for (int k = 0; k < NW; k++)
            if ($urandom_range(0, 2) != 0) begin
               logic [AW-1:0] a;
               a = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
               set_wr(k, a, $urandom, $urandom);
            end
         for (int p = 0; p < NR; p++) set_rd(p, AW'($urandom_range(0, 9)));
         bus.iss_en   = 1'($urandom_range(0, 1));
         bus.iss_addr = AW'($urandom_range(0, 9));
         if (i % 250 == 125) #2 reset = 1'b1;
      end

      step();
      idle();
      reset = 1'b0;
      step();
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
